alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Requester side of the execute-stage ALU interface: takes RV32I instructions with register operands and decodes them into an ALU op code plus operand A/B.
- Drives the combinational ALU through its alu_op/operand_a/operand_b/result port set, then registers the returned result with write-back metadata.
- Two-stage valid/ready pipeline between the register-read stage and the write-back stage.

Parameters:
- DATA_WIDTH, 32, width of operands, PC and result.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  instruction offered.
- in_ready  output  1  instruction accepted when in_valid && in_ready.
- in_instr  input  32  raw RV32I instruction.
- in_pc  input  DATA_WIDTH  instruction address.
- in_rs1_val  input  DATA_WIDTH  rs1 value.
- in_rs2_val  input  DATA_WIDTH  rs2 value.
- alu_op_o  output  4  ALU op code, using the `ALU_* encodings from defines.v.
- alu_a_o  output  DATA_WIDTH  ALU operand_a.
- alu_b_o  output  DATA_WIDTH  ALU operand_b.
- alu_result_i  input  DATA_WIDTH  ALU result (combinational from alu_*_o).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts.
- out_result  output  DATA_WIDTH  captured ALU result.
- out_rd  output  5  destination register.
- out_we  output  1  register write enable; 0 for branch/store and for rd=x0.
- out_is_branch  output  1  instruction was a conditional branch.
- out_br_taken  output  1  branch condition true.
- out_illegal  output  1  unsupported encoding (see Optional Feature).

Behaviour:
- Stage D register holds: d_valid, alu_op, a, b, rd, we, is_branch, br_invert, illegal. alu_op_o/alu_a_o/alu_b_o are driven directly from stage D.
- Stage R register holds: r_valid, result, rd, we, is_branch, br_taken, illegal. All out_* ports come from stage R.
- Handshake:
  - r_adv = !r_valid || out_ready
  - in_ready = !d_valid || r_adv (combinational, no dependence on in_valid)
  - d captures on in_valid && in_ready
  - r captures d when d_valid && r_adv
- Latency: accepted at edge N, stage D valid after N, out_valid after N+1. Sustains 1 instruction/cycle with out_ready held high.
- out_* signals stay stable while out_valid && !out_ready.
- Decode (opcode in_instr[6:0]):
  - OP-IMM 0010011: a = rs1, b = I-imm sign-extended. funct3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND, 001 SLL, 101 SRL, or SRA when instr[30]=1. Shift amount is b[4:0].
  - OP 0110011: a = rs1, b = rs2. Same funct3 map, except funct3 000 with instr[30]=1 is SUB.
  - LUI 0110111: ADD, a = 0, b = U-imm.
  - AUIPC 0010111: ADD, a = pc, b = U-imm.
  - JAL 1101111 / JALR 1100111: ADD, a = pc, b = 4 (link value).
  - LOAD 0000011: ADD, a = rs1, b = I-imm, we = 1.
  - STORE 0100011: ADD, a = rs1, b = S-imm, we = 0.
  - BRANCH 1100011: a = rs1, b = rs2, we = 0, is_branch = 1.
    - BEQ: SEQ. BNE: SEQ, invert.
    - BLT: SLT. BGE: SLT, invert.
    - BLTU: SLTU. BGEU: SLTU, invert.
    - funct3 010/011 are illegal.
  - out_br_taken = alu_result_i[0] ^ br_invert, captured into stage R. It is 0 for non-branches.
- we is forced to 0 when rd = 0.
- All arithmetic is DATA_WIDTH wrap-around; immediates are sign-extended from bit 31.
- Reset (async, rst_n low): d_valid = 0, r_valid = 0, and every stage register field = 0. As a result all out_* = 0 and alu_op_o/alu_a_o/alu_b_o = 0.
  - Reset mid-transfer discards both in-flight instructions.
  - in_ready = 1 on the first cycle after release.
- Simultaneous accept into D and transfer D→R in the same edge is legal, with no bubble.

Optional Feature:
- Macro ALU_ILLEGAL_CHECK_EN.
- Defined: any opcode not listed above, or an illegal funct3/funct7 (OP with funct7 other than 0000000/0100000, shift-imm with bad funct7, BRANCH funct3 010/011), sets illegal = 1, we = 0, is_branch = 0, alu_op = `ALU_ADD, a = b = 0. out_illegal = 1 with result 0.
- Undefined: no checking. Unknown opcodes decode as OP-IMM ADD with we = 0, and out_illegal is tied 0.

Test Plan:
- ADDI x5,x1,-1 with rs1=0x10 (instr 0xFFF08293) → 2 cycles later out_valid=1, out_result=0x0000000F, out_rd=5, out_we=1.
- SUB x3,x1,x2 with rs1=5, rs2=7 → out_result=0xFFFFFFFE. SRAI x4,x1,4 with rs1=0x80000000 → out_result=0xF8000000.
- BGE x1,x2 with rs1=0xFFFFFFFF, rs2=1 → out_is_branch=1, out_br_taken=0, out_we=0. BLTU on the same operands → out_br_taken=0. BNE 3,4 → out_br_taken=1.
- Back-to-back stream of 4 ADDIs with out_ready=1 → 4 consecutive out_valid cycles. Hold out_ready=0 for 3 cycles → in_ready drops after 2 accepts, outputs stay stable, no loss or duplication.
- Assert rst_n=0 mid-stream with 2 instructions in flight → out_valid=0 and alu_op_o=0 immediately. After release, first new instruction emerges 2 cycles after acceptance.
- With ALU_ILLEGAL_CHECK_EN: opcode 0x7F → out_illegal=1, out_we=0, out_result=0. Without the macro → out_illegal=0, out_we=0.

Source files
------------

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - bundle between register-read, the external ALU and write-back for alu_issue
//
// ALU op encodings (`ALU_*) are defined here unless the build already provides them.
//
// Signals (slave = alu_issue side):
//   in_valid/in_ready           instruction handshake
//   in_instr, in_pc             raw RV32I instruction and its address
//   in_rs1_val, in_rs2_val      register operands
//   alu_op_o, alu_a_o, alu_b_o  request to the combinational ALU
//   alu_result_i                ALU result
//   out_valid/out_ready         write-back handshake
//   out_result, out_rd, out_we  captured result and write-back metadata
//   out_is_branch, out_br_taken conditional branch outcome
//   out_illegal                 unsupported encoding flag

`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`define ALU_SEQ  4'd10
`endif

interface alu_issue_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [31:0]           in_instr;
   logic [DATA_WIDTH-1:0] in_pc;
   logic [DATA_WIDTH-1:0] in_rs1_val;
   logic [DATA_WIDTH-1:0] in_rs2_val;
   logic [3:0]            alu_op_o;
   logic [DATA_WIDTH-1:0] alu_a_o;
   logic [DATA_WIDTH-1:0] alu_b_o;
   logic [DATA_WIDTH-1:0] alu_result_i;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_result;
   logic [4:0]            out_rd;
   logic                  out_we;
   logic                  out_is_branch;
   logic                  out_br_taken;
   logic                  out_illegal;

   modport slave (
      input  in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val,
      output in_ready,
      output alu_op_o, alu_a_o, alu_b_o,
      input  alu_result_i,
      output out_valid, out_result, out_rd, out_we, out_is_branch, out_br_taken, out_illegal,
      input  out_ready
   );

   modport master (
      output in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val,
      input  in_ready,
      input  alu_op_o, alu_a_o, alu_b_o,
      output alu_result_i,
      input  out_valid, out_result, out_rd, out_we, out_is_branch, out_br_taken, out_illegal,
      output out_ready
   );
endinterface

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV32I decode/issue stage driving an external combinational ALU
//
// Two-stage valid/ready pipeline: stage D holds the decoded ALU request (drives the
// ALU directly), stage R holds the captured result plus write-back metadata.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears both stages
//   bus    alu_issue_if.slave (instruction in, ALU request/result, write-back out)
//
// Optional feature macro: ALU_ILLEGAL_CHECK_EN
//   defined   - unsupported opcodes / funct3 / funct7 flag out_illegal, result 0, no write
//   undefined - no checking; unknown opcodes decode as an ADD of rs1 + I-imm with no write

module alu_issue #(
   parameter int DATA_WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_issue_if.slave bus
);

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Sign-extend a 32-bit immediate to the datapath width.
   function automatic logic [DATA_WIDTH-1:0] sext32(input logic [31:0] v);
      return DATA_WIDTH'($signed(v));
   endfunction

   // Shared funct3 map of OP-IMM and OP; alt selects SRA over SRL.
   function automatic logic [3:0] f3_to_op(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'b000:  op = `ALU_ADD;
         3'b001:  op = `ALU_SLL;
         3'b010:  op = `ALU_SLT;
         3'b011:  op = `ALU_SLTU;
         3'b100:  op = `ALU_XOR;
         3'b101:  op = alt ? `ALU_SRA : `ALU_SRL;
         3'b110:  op = `ALU_OR;
         default: op = `ALU_AND;
      endcase
      return op;
   endfunction

   // ---------------------------------------------------------------- decode
   logic [6:0]            w_opcode;
   logic [2:0]            w_funct3;
   logic [6:0]            w_funct7;
   logic [4:0]            w_rd;
   logic [DATA_WIDTH-1:0] w_imm_i;
   logic [DATA_WIDTH-1:0] w_imm_s;
   logic [DATA_WIDTH-1:0] w_imm_u;

   assign w_opcode = bus.in_instr[6:0];
   assign w_funct3 = bus.in_instr[14:12];
   assign w_funct7 = bus.in_instr[31:25];
   assign w_rd     = bus.in_instr[11:7];
   assign w_imm_i  = sext32({{20{bus.in_instr[31]}}, bus.in_instr[31:20]});
   assign w_imm_s  = sext32({{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]});
   assign w_imm_u  = sext32({bus.in_instr[31:12], 12'b0});

   logic                  w_illegal;
   logic [3:0]            w_dec_op;
   logic [DATA_WIDTH-1:0] w_dec_a;
   logic [DATA_WIDTH-1:0] w_dec_b;
   logic                  w_dec_we;
   logic                  w_dec_is_branch;
   logic                  w_dec_br_invert;

`ifdef ALU_ILLEGAL_CHECK_EN
   always_comb begin
      w_illegal = 1'b0;
      case (w_opcode)
         OPC_OP_IMM: begin
            if (w_funct3 == 3'b001 && w_funct7 != F7_BASE)
               w_illegal = 1'b1;
            else if (w_funct3 == 3'b101 && w_funct7 != F7_BASE && w_funct7 != F7_ALT)
               w_illegal = 1'b1;
         end
         OPC_OP: begin
            if (w_funct7 != F7_BASE && w_funct7 != F7_ALT)
               w_illegal = 1'b1;
         end
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE: w_illegal = 1'b0;
         OPC_BRANCH: begin
            if (w_funct3 == 3'b010 || w_funct3 == 3'b011)
               w_illegal = 1'b1;
         end
         default: w_illegal = 1'b1;
      endcase
   end
`else
   assign w_illegal = 1'b0;
`endif

   always_comb begin
      // Default is the I-type ADD shape (LOAD, and unknown opcodes without checking).
      w_dec_op        = `ALU_ADD;
      w_dec_a         = bus.in_rs1_val;
      w_dec_b         = w_imm_i;
      w_dec_we        = 1'b1;
      w_dec_is_branch = 1'b0;
      w_dec_br_invert = 1'b0;
      case (w_opcode)
         OPC_OP_IMM: w_dec_op = f3_to_op(w_funct3, bus.in_instr[30]);
         OPC_OP: begin
            w_dec_b = bus.in_rs2_val;
            if (w_funct3 == 3'b000 && bus.in_instr[30])
               w_dec_op = `ALU_SUB;
            else
               w_dec_op = f3_to_op(w_funct3, bus.in_instr[30]);
         end
         OPC_LUI: begin
            w_dec_a = '0;
            w_dec_b = w_imm_u;
         end
         OPC_AUIPC: begin
            w_dec_a = bus.in_pc;
            w_dec_b = w_imm_u;
         end
         OPC_JAL, OPC_JALR: begin
            // Only the link value pc+4 goes through the ALU.
            w_dec_a = bus.in_pc;
            w_dec_b = DATA_WIDTH'(4);
         end
         OPC_LOAD: w_dec_we = 1'b1;
         OPC_STORE: begin
            w_dec_b  = w_imm_s;
            w_dec_we = 1'b0;
         end
         OPC_BRANCH: begin
            w_dec_b         = bus.in_rs2_val;
            w_dec_we        = 1'b0;
            w_dec_is_branch = 1'b1;
            // Odd funct3 is the negated form of the even one; the ALU computes the
            // positive compare and stage R flips it.
            w_dec_br_invert = w_funct3[0];
            case (w_funct3[2:1])
               2'b10:   w_dec_op = `ALU_SLT;
               2'b11:   w_dec_op = `ALU_SLTU;
               default: w_dec_op = `ALU_SEQ;
            endcase
            if (w_funct3[2:1] == 2'b01)
               w_dec_br_invert = 1'b0;
         end
         default: w_dec_we = 1'b0;
      endcase

      if (w_illegal) begin
         w_dec_op        = `ALU_ADD;
         w_dec_a         = '0;
         w_dec_b         = '0;
         w_dec_we        = 1'b0;
         w_dec_is_branch = 1'b0;
         w_dec_br_invert = 1'b0;
      end

      if (w_rd == 5'd0)
         w_dec_we = 1'b0;
   end

   // ---------------------------------------------------------------- pipeline
   logic                  r_d_valid;
   logic [3:0]            r_d_op;
   logic [DATA_WIDTH-1:0] r_d_a;
   logic [DATA_WIDTH-1:0] r_d_b;
   logic [4:0]            r_d_rd;
   logic                  r_d_we;
   logic                  r_d_is_branch;
   logic                  r_d_br_invert;
   logic                  r_d_illegal;

   logic                  r_r_valid;
   logic [DATA_WIDTH-1:0] r_r_result;
   logic [4:0]            r_r_rd;
   logic                  r_r_we;
   logic                  r_r_is_branch;
   logic                  r_r_br_taken;
   logic                  r_r_illegal;

   logic w_r_adv;
   logic w_d_load;
   logic w_r_load;

   assign w_r_adv      = !r_r_valid || bus.out_ready;
   assign bus.in_ready = !r_d_valid || w_r_adv;
   assign w_d_load     = bus.in_valid && bus.in_ready;
   assign w_r_load     = r_d_valid && w_r_adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d_valid     <= 1'b0;
         r_d_op        <= '0;
         r_d_a         <= '0;
         r_d_b         <= '0;
         r_d_rd        <= '0;
         r_d_we        <= 1'b0;
         r_d_is_branch <= 1'b0;
         r_d_br_invert <= 1'b0;
         r_d_illegal   <= 1'b0;
         r_r_valid     <= 1'b0;
         r_r_result    <= '0;
         r_r_rd        <= '0;
         r_r_we        <= 1'b0;
         r_r_is_branch <= 1'b0;
         r_r_br_taken  <= 1'b0;
         r_r_illegal   <= 1'b0;
      end else begin
         // A new instruction may enter D on the same edge the old one moves to R.
         if (w_d_load) begin
            r_d_valid     <= 1'b1;
            r_d_op        <= w_dec_op;
            r_d_a         <= w_dec_a;
            r_d_b         <= w_dec_b;
            r_d_rd        <= w_rd;
            r_d_we        <= w_dec_we;
            r_d_is_branch <= w_dec_is_branch;
            r_d_br_invert <= w_dec_br_invert;
            r_d_illegal   <= w_illegal;
         end else if (w_r_load) begin
            r_d_valid <= 1'b0;
         end

         if (w_r_load) begin
            r_r_valid     <= 1'b1;
            r_r_result    <= bus.alu_result_i;
            r_r_rd        <= r_d_rd;
            r_r_we        <= r_d_we;
            r_r_is_branch <= r_d_is_branch;
            r_r_br_taken  <= r_d_is_branch && (bus.alu_result_i[0] ^ r_d_br_invert);
            r_r_illegal   <= r_d_illegal;
         end else if (bus.out_ready) begin
            r_r_valid <= 1'b0;
         end
      end
   end

   assign bus.alu_op_o      = r_d_op;
   assign bus.alu_a_o       = r_d_a;
   assign bus.alu_b_o       = r_d_b;

   assign bus.out_valid     = r_r_valid;
   assign bus.out_result    = r_r_result;
   assign bus.out_rd        = r_r_rd;
   assign bus.out_we        = r_r_we;
   assign bus.out_is_branch = r_r_is_branch;
   assign bus.out_br_taken  = r_r_br_taken;
   assign bus.out_illegal   = r_r_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue with a behavioural RV32I reference

module tb_alu_issue;
   localparam int DW = 32;

`ifdef ALU_ILLEGAL_CHECK_EN
   localparam bit ILL_EN = 1'b1;
`else
   localparam bit ILL_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   alu_issue_if #(.DATA_WIDTH(DW)) bus ();
   alu_issue #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic [31:0] result;
      logic [4:0]  rd;
      logic        we;
      logic        is_branch;
      logic        br_taken;
      logic        illegal;
      int          acc_cyc;
      bit          lat_chk;
   } exp_t;

   exp_t sb_q[$];
   int   pop_cyc[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   n_acc = 0;
   int   cyc = 0;
   int   ready_mode = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // External combinational ALU.
   function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         `ALU_ADD:  return a + b;
         `ALU_SUB:  return a - b;
         `ALU_SLL:  return a << b[4:0];
         `ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
         `ALU_SLTU: return {31'b0, a < b};
         `ALU_XOR:  return a ^ b;
         `ALU_SRL:  return a >> b[4:0];
         `ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
         `ALU_OR:   return a | b;
         `ALU_AND:  return a & b;
         `ALU_SEQ:  return {31'b0, a == b};
         default:   return 32'h0;
      endcase
   endfunction

   always_comb bus.alu_result_i = alu_model(bus.alu_op_o, bus.alu_a_o, bus.alu_b_o);

   // Reference: what an RV32I execute stage must report for one instruction.
   function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] rs1, input logic [31:0] rs2);
      exp_t e;
      logic [6:0]  opc = ins[6:0];
      logic [2:0]  f3  = ins[14:12];
      logic [6:0]  f7  = ins[31:25];
      logic [31:0] imm_i = {{20{ins[31]}}, ins[31:20]};
      logic [31:0] imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      logic [31:0] imm_u = {ins[31:12], 12'b0};
      logic [31:0] opnd;
      logic [31:0] r = 32'h0;
      bit writes = 1'b1;
      bit legal = 1'b1;
      bit br = 1'b0;
      bit taken = 1'b0;
      case (opc)
         7'h13, 7'h33: begin
            opnd = (opc == 7'h13) ? imm_i : rs2;
            if (opc == 7'h33) legal = (f7 == 7'h00 || f7 == 7'h20);
            case (f3)
               3'd0: r = (opc == 7'h33 && ins[30]) ? rs1 - opnd : rs1 + opnd;
               3'd1: begin r = rs1 << opnd[4:0]; if (opc == 7'h13) legal = (f7 == 7'h00); end
               3'd2: r = ($signed(rs1) < $signed(opnd)) ? 32'd1 : 32'd0;
               3'd3: r = (rs1 < opnd) ? 32'd1 : 32'd0;
               3'd4: r = rs1 ^ opnd;
               3'd5: begin
                  r = ins[30] ? 32'($signed(rs1) >>> opnd[4:0]) : rs1 >> opnd[4:0];
                  if (opc == 7'h13) legal = (f7 == 7'h00 || f7 == 7'h20);
               end
               3'd6: r = rs1 | opnd;
               default: r = rs1 & opnd;
            endcase
         end
         7'h37: r = imm_u;
         7'h17: r = pc + imm_u;
         7'h6F, 7'h67: r = pc + 32'd4;
         7'h03: r = rs1 + imm_i;
         7'h23: begin r = rs1 + imm_s; writes = 1'b0; end
         7'h63: begin
            writes = 1'b0;
            br = 1'b1;
            case (f3)
               3'd4, 3'd5: r = ($signed(rs1) < $signed(rs2)) ? 32'd1 : 32'd0;
               3'd6, 3'd7: r = (rs1 < rs2) ? 32'd1 : 32'd0;
               default:    r = (rs1 == rs2) ? 32'd1 : 32'd0;
            endcase
            taken = r[0] ^ (f3 inside {3'd1, 3'd5, 3'd7});
            legal = !(f3 inside {3'd2, 3'd3});
         end
         default: begin r = rs1 + imm_i; writes = 1'b0; legal = 1'b0; end
      endcase
      e.illegal = 1'b0;
      if (ILL_EN && !legal) begin
         r = 32'h0; writes = 1'b0; br = 1'b0; taken = 1'b0; e.illegal = 1'b1;
      end
      e.result    = r;
      e.rd        = ins[11:7];
      e.we        = writes && (ins[11:7] != 5'd0);
      e.is_branch = br;
      e.br_taken  = taken;
      e.acc_cyc   = 0;
      e.lat_chk   = 1'b0;
      return e;
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r = $urandom;
      logic [11:0] imm = r[31:20];
      logic [2:0]  f3 = 3'($urandom_range(0, 7));
      int idx;
      case ($urandom_range(0, 8))
         0: begin
            if (f3 == 3'd1) imm[11:5] = 7'h00;
            if (f3 == 3'd5) imm[11:5] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            return enc_i(imm, r[19:15], f3, r[11:7], 7'h13);
         end
         1: return enc_r($urandom_range(0, 1) ? 7'h20 : 7'h00, r[24:20], r[19:15], f3, r[11:7], 7'h33);
         2: return {r[31:7], 7'h37};
         3: return {r[31:7], 7'h17};
         4: return {r[31:7], 7'h6F};
         5: return enc_i(imm, r[19:15], 3'd0, r[11:7], 7'h67);
         6: return enc_i(imm, r[19:15], f3, r[11:7], 7'h03);
         7: return {r[31:25], r[24:20], r[19:15], f3, r[11:7], 7'h23};
         default: begin
            idx = $urandom_range(0, 5);
            f3 = (idx < 2) ? 3'(idx) : 3'(idx + 2);
            return {r[31:25], r[24:20], r[19:15], f3, r[11:7], 7'h63};
         end
      endcase
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Sole driver of out_ready: 0 = held high, 1 = held low, 2 = random.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = 1'b0;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: pops an expectation per output handshake, and checks outputs hold during stalls.
   initial begin
      exp_t e;
      bit stall_prev = 1'b0;
      logic [41:0] snap = '0;
      logic [41:0] now;
      forever begin
         @(negedge clk);
         now = {bus.out_valid, bus.out_result, bus.out_rd, bus.out_we,
                bus.out_is_branch, bus.out_br_taken, bus.out_illegal};
         if (!rst_n) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) chk("stall_stable", 64'(now), 64'(snap));
            stall_prev = bus.out_valid && !bus.out_ready;
            snap = now;
            if (bus.out_valid && bus.out_ready) begin
               chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
               if (sb_q.size() != 0) begin
                  e = sb_q.pop_front();
                  chk("out_fields", 64'(now[40:0]),
                      64'({e.result, e.rd, e.we, e.is_branch, e.br_taken, e.illegal}));
                  if (e.lat_chk) chk("latency", 64'(cyc - e.acc_cyc), 64'd2);
                  pop_cyc.push_back(cyc);
               end
            end
         end
      end
   end

   // Offers one instruction starting just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input bit lat);
      exp_t e;
      bit done = 1'b0;
      bus.in_valid   = 1'b1;
      bus.in_instr   = ins;
      bus.in_pc      = pc;
      bus.in_rs1_val = rs1;
      bus.in_rs2_val = rs2;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            e = ref_model(ins, pc, rs1, rs2);
            e.acc_cyc = cyc;
            e.lat_chk = lat;
            sb_q.push_back(e);
            n_acc++;
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) chk("send_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && !bus.out_valid) done = 1'b1;
      end
      if (!done) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [31:0] rs1;
      logic [31:0] rs2;
      int acc0;
      bus.in_valid   = 1'b0;
      bus.in_instr   = 32'h0;
      bus.in_pc      = 32'h0;
      bus.in_rs1_val = 32'h0;
      bus.in_rs2_val = 32'h0;

      #2 rst_n = 1'b0;
      idle_cycles(3);
      @(negedge clk);
      chk("reset_out", 64'({bus.out_valid, bus.out_result, bus.out_rd, bus.out_we,
                            bus.out_is_branch, bus.out_br_taken, bus.out_illegal}), 64'd0);
      chk("reset_alu_op", 64'(bus.alu_op_o), 64'd0);
      chk("reset_alu_ab", {bus.alu_a_o, bus.alu_b_o}, 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Directed cases from the test plan.
      send(32'hFFF08293, 32'h100, 32'h10, 32'h0, 1'b1);
      drain();
      send(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h104, 32'd5, 32'd7, 1'b1);
      send(enc_i(12'h404, 5'd1, 3'd5, 5'd4, 7'h13), 32'h108, 32'h80000000, 32'h0, 1'b0);
      send({7'h0, 5'd2, 5'd1, 3'd5, 5'd0, 7'h63}, 32'h10C, 32'hFFFFFFFF, 32'd1, 1'b0);
      send({7'h0, 5'd2, 5'd1, 3'd6, 5'd0, 7'h63}, 32'h110, 32'hFFFFFFFF, 32'd1, 1'b0);
      send({7'h0, 5'd2, 5'd1, 3'd1, 5'd0, 7'h63}, 32'h114, 32'd3, 32'd4, 1'b0);
      send(32'hFFFFF0B7, 32'h118, 32'h0, 32'h0, 1'b0);
      send(32'h00001117, 32'h11C, 32'h0, 32'h0, 1'b0);
      send(32'h008000EF, 32'h120, 32'h0, 32'h0, 1'b0);
      send(enc_i(12'h005, 5'd1, 3'd0, 5'd0, 7'h13), 32'h124, 32'd9, 32'h0, 1'b0);
      send(32'h000003FF, 32'h128, 32'h100, 32'h0, 1'b0);
      drain();

      // Four back-to-back ADDIs with out_ready held high.
      for (int i = 0; i < 4; i++)
         send(enc_i(12'(i + 1), 5'd1, 3'd0, 5'd6, 7'h13), 32'h200, 32'(i * 16), 32'h0, 1'b1);
      drain();
      chk("b2b_consecutive", 64'(pop_cyc[pop_cyc.size() - 1] - pop_cyc[pop_cyc.size() - 4]), 64'd3);

      // Backpressure: two accepts fill the pipe, then in_ready must drop.
      ready_mode = 1;
      idle_cycles(2);
      acc0 = n_acc;
      fork
         begin
            for (int i = 0; i < 4; i++)
               send(enc_i(12'h010, 5'd1, 3'd4, 5'd7, 7'h13), 32'h300, 32'(i * 3 + 1), 32'h0, 1'b0);
         end
         begin
            repeat (3) @(negedge clk);
            chk("bp_accepts", 64'(n_acc - acc0), 64'd2);
            chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
            ready_mode = 0;
         end
      join
      drain();

      // Reset with two instructions in flight.
      ready_mode = 1;
      idle_cycles(2);
      send(enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd8, 7'h33), 32'h400, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0);
      send(enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd9, 7'h33), 32'h404, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
      chk("pre_reset_op", 64'(bus.alu_op_o), 64'(`ALU_XOR));
      rst_n = 1'b0;
      #1;
      chk("mid_reset_out_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_reset_alu_op", 64'(bus.alu_op_o), 64'd0);
      sb_q.delete();
      ready_mode = 0;
      idle_cycles(2);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_midreset", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      send(enc_i(12'h7FF, 5'd1, 3'd0, 5'd10, 7'h13), 32'h500, 32'h1, 32'h0, 1'b1);
      drain();

      // Randomized traffic with random backpressure.
      ready_mode = 2;
      for (int i = 0; i < 300; i++) begin
         idle_cycles($urandom_range(0, 2));
         rs1 = $urandom;
         if ($urandom_range(0, 3) == 0) rs1 = 32'($urandom_range(0, 8));
         rs2 = $urandom_range(0, 1) ? rs1 : $urandom;
         if ($urandom_range(0, 3) == 0) rs2 = 32'($urandom_range(0, 8));
         send(rand_instr(), $urandom & 32'hFFFF_FFFC, rs1, rs2, 1'b0);
      end
      ready_mode = 0;
      drain();
      chk("sb_empty_at_end", 64'(sb_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
